// File: rtl/arith_pkg.sv
// arith_pkg: shared state encodings and counter sizing for bit-serial arithmetic
package arith_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/fulladd_cell.sv
// fulladd_cell: one-bit combinational full adder
// ports: a, b, cin -> s (sum), cout (carry)
module fulladd_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, {cout,S} = a + b + cin over WIDTH cycles
// ports: clk, rst (sync, active-high), start, a, b, cin in; S, cout, busy, done out (all registered)
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = cnt_w(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, busy_q, done_q;
  logic             sum, c_nxt, accept, shift, last;
  fulladd_cell u_fa (.a(a_q[0]), .b(b_q[0]), .cin(carry_q), .s(sum), .cout(c_nxt));
  assign accept = (state_q == ST_IDLE) && start;
  assign shift  = (state_q == ST_SHIFT);
  assign last   = (cnt_q == CW'(WIDTH - 1));
  always_comb begin
    // encoding 3 and DONE both fall back to IDLE
    state_d = accept ? ST_SHIFT : shift ? (last ? ST_DONE : ST_SHIFT) : ST_IDLE;
    a_d     = accept ? a : shift ? a_q >> 1 : a_q;
    b_d     = accept ? b : shift ? b_q >> 1 : b_q;
    carry_d = accept ? cin : shift ? c_nxt : carry_q;
    cnt_d   = accept ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    // sum bits enter at the MSB so the result is LSB-aligned after WIDTH shifts
    s_d     = accept ? '0 : shift ? {sum, s_q[WIDTH-1:1]} : s_q;
    cout_d  = accept ? 1'b0 : (shift && last) ? c_nxt : cout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= (state_d == ST_SHIFT);
      done_q  <= (state_d == ST_DONE);
    end
  end
  assign S    = s_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
